// File: rtl/game_master_fsm_multi_if.sv
// Bus bundle between the game master and the sprite/timer/collision blocks.
interface game_master_fsm_multi_if #(
  parameter int unsigned N_TARGETS = 2,
  parameter int unsigned N_SHOTS   = 3,
  parameter int unsigned SCORE_W   = 8
);
  localparam int unsigned SHOT_W = $clog2(N_SHOTS + 1);

  logic                 key;
  logic [N_TARGETS-1:0] sprite_target_write_xy;
  logic [N_TARGETS-1:0] sprite_target_write_dxy;
  logic [N_TARGETS-1:0] sprite_target_enable_update;
  logic [N_TARGETS-1:0] sprite_target_within_screen;
  logic                 sprite_torpedo_write_xy;
  logic                 sprite_torpedo_write_dxy;
  logic                 sprite_torpedo_enable_update;
  logic                 sprite_torpedo_within_screen;
  logic [N_TARGETS-1:0] collision;
  logic                 end_of_game_timer_start;
  logic                 end_of_game_timer_running;
  logic                 game_won;
  logic [N_TARGETS-1:0] targets_alive;
  logic [SHOT_W-1:0]    shots_left;
  logic [SCORE_W-1:0]   score;

  // Game master side
  modport master (
    input  key, sprite_target_within_screen, sprite_torpedo_within_screen,
           collision, end_of_game_timer_running,
    output sprite_target_write_xy, sprite_target_write_dxy, sprite_target_enable_update,
           sprite_torpedo_write_xy, sprite_torpedo_write_dxy, sprite_torpedo_enable_update,
           end_of_game_timer_start, game_won, targets_alive, shots_left, score
  );

  // Sprite / timer / collision side
  modport slave (
    output key, sprite_target_within_screen, sprite_torpedo_within_screen,
           collision, end_of_game_timer_running,
    input  sprite_target_write_xy, sprite_target_write_dxy, sprite_target_enable_update,
           sprite_torpedo_write_xy, sprite_torpedo_write_dxy, sprite_torpedo_enable_update,
           end_of_game_timer_start, game_won, targets_alive, shots_left, score
  );
endinterface

// File: rtl/game_master_fsm_multi.sv
// Torpedo game master: one round against N_TARGETS targets with N_SHOTS torpedoes,
// alive tracking and a saturating score that survives across rounds.
module game_master_fsm_multi #(
  parameter int unsigned N_TARGETS = 2,
  parameter int unsigned N_SHOTS   = 3,
  parameter int unsigned SCORE_W   = 8
) (
  input  logic clk,
  input  logic reset,
  game_master_fsm_multi_if.master bus
);
  localparam int unsigned SHOT_W = $clog2(N_SHOTS + 1);
  localparam int unsigned SUM_W  = SCORE_W + 4;
  localparam logic [SUM_W-1:0] SCORE_MAX = SUM_W'({SCORE_W{1'b1}});

  typedef enum logic [3:0] {
    S_IDLE,
    S_START_ROUND,
    S_WAIT_KEY,
    S_LAUNCH,
    S_FLY,
    S_HIT,
    S_START_END_TIMER,
    S_WON,
    S_LOST
  } state_t;

  state_t               state;
  logic [N_TARGETS-1:0] alive;
  logic [N_TARGETS-1:0] hit_mask;
  logic [SHOT_W-1:0]    shots_left;
  logic [SCORE_W-1:0]   score;

  logic                 alive_off;
  logic                 round_over;
  logic                 shots_avail;
  logic [N_TARGETS-1:0] live_hits;
  logic [N_TARGETS-1:0] alive_after_hit;
  logic [SUM_W-1:0]     score_sum;
  logic [SCORE_W-1:0]   score_next;

  function automatic logic [SUM_W-1:0] popcount(input logic [N_TARGETS-1:0] v);
    logic [SUM_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(N_TARGETS); i++) c = c + SUM_W'(v[i]);
    return c;
  endfunction

  // Round-status and scoring helpers
  always_comb begin
    alive_off       = |(alive & ~bus.sprite_target_within_screen);
    shots_avail     = (shots_left != '0);
    round_over      = (alive == '0) | alive_off | !shots_avail;
    live_hits       = bus.collision & alive;
    alive_after_hit = alive & ~hit_mask;
    score_sum       = SUM_W'(score) + popcount(hit_mask);
    score_next      = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  end

  // Round sequencer with alive mask, magazine, hit capture and score
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      alive      <= '0;
      hit_mask   <= '0;
      shots_left <= '0;
      score      <= '0;
    end else begin
      case (state)
        S_IDLE: state <= S_START_ROUND;
        S_START_ROUND: begin
          alive      <= '1;
          shots_left <= SHOT_W'(N_SHOTS);
          state      <= S_WAIT_KEY;
        end
        S_WAIT_KEY: begin
          if (bus.key && shots_avail) state <= S_LAUNCH;
          else if (round_over)        state <= S_START_END_TIMER;
        end
        S_LAUNCH: begin
          shots_left <= shots_left - SHOT_W'(1);
          state      <= S_FLY;
        end
        S_FLY: begin
          hit_mask <= live_hits;
          if (|live_hits)                             state <= S_HIT;
          else if (alive_off)                         state <= S_START_END_TIMER;
          else if (!bus.sprite_torpedo_within_screen) state <= shots_avail ? S_WAIT_KEY
                                                                          : S_START_END_TIMER;
        end
        S_HIT: begin
          alive <= alive_after_hit;
          score <= score_next;
          state <= ((alive_after_hit == '0) || !shots_avail) ? S_START_END_TIMER : S_WAIT_KEY;
        end
        S_START_END_TIMER: state <= (alive == '0) ? S_WON : S_LOST;
        S_WON, S_LOST: if (!bus.end_of_game_timer_running) state <= S_START_ROUND;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore decode of sprite/timer controls from the state register
  always_comb begin
    bus.sprite_target_write_xy       = '0;
    bus.sprite_target_write_dxy      = '0;
    bus.sprite_target_enable_update  = '0;
    bus.sprite_torpedo_write_xy      = 1'b0;
    bus.sprite_torpedo_write_dxy     = 1'b0;
    bus.sprite_torpedo_enable_update = 1'b0;
    bus.end_of_game_timer_start      = 1'b0;
    bus.game_won                     = 1'b0;
    case (state)
      S_START_ROUND: begin
        bus.sprite_target_write_xy  = '1;
        bus.sprite_target_write_dxy = '1;
        bus.sprite_torpedo_write_xy = 1'b1;
      end
      S_WAIT_KEY: begin
        bus.sprite_target_enable_update = alive;
        bus.sprite_torpedo_write_dxy    = 1'b1;
      end
      S_LAUNCH: bus.sprite_torpedo_write_xy = 1'b1;
      S_FLY: begin
        bus.sprite_target_enable_update  = alive;
        bus.sprite_torpedo_write_dxy     = 1'b1;
        bus.sprite_torpedo_enable_update = 1'b1;
      end
      S_START_END_TIMER: bus.end_of_game_timer_start = 1'b1;
      S_WON:             bus.game_won = 1'b1;
      default: ;
    endcase
  end

  // Status outputs straight from their registers
  always_comb begin
    bus.targets_alive = alive;
    bus.shots_left    = shots_left;
    bus.score         = score;
  end
endmodule

// File: tb/tb_game_master_fsm_multi.sv
// Directed scoreboard bench for game_master_fsm_multi (2 targets, 3 shots, 2-bit score).
module tb_game_master_fsm_multi;
  localparam int unsigned NT = 2;
  localparam int unsigned NS = 3;
  localparam int unsigned SW = 2;

  localparam int S_IDLE   = 0;
  localparam int S_START  = 1;
  localparam int S_WAIT   = 2;
  localparam int S_LAUNCH = 3;
  localparam int S_FLY    = 4;
  localparam int S_HIT    = 5;
  localparam int S_SET    = 6;
  localparam int S_WON    = 7;
  localparam int S_LOST   = 8;

  logic clk;
  logic reset;

  game_master_fsm_multi_if #(.N_TARGETS(NT), .N_SHOTS(NS), .SCORE_W(SW)) bus ();

  game_master_fsm_multi #(.N_TARGETS(NT), .N_SHOTS(NS), .SCORE_W(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Expected control vector {twxy, twdxy, ten, torxy, tordxy, toren, tstart, won}
  function automatic logic [10:0] ctl(input int s, input logic [1:0] a);
    case (s)
      S_START:  return 11'b11_11_00_1_0_0_0_0;
      S_WAIT:   return {4'b0000, a, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      S_LAUNCH: return 11'b00_00_00_1_0_0_0_0;
      S_FLY:    return {4'b0000, a, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      S_SET:    return 11'b00_00_00_0_0_0_1_0;
      S_WON:    return 11'b00_00_00_0_0_0_0_1;
      default:  return 11'b0;
    endcase
  endfunction

  function automatic logic [10:0] obs_ctl();
    return {bus.sprite_target_write_xy, bus.sprite_target_write_dxy,
            bus.sprite_target_enable_update, bus.sprite_torpedo_write_xy,
            bus.sprite_torpedo_write_dxy, bus.sprite_torpedo_enable_update,
            bus.end_of_game_timer_start, bus.game_won};
  endfunction

  task automatic push(input string tag, input logic [15:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic pop_check(input logic [15:0] obs);
    exp_t x;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: observed %0h required an expected entry", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %0h required %0h", x.tag, obs, x.exp);
      end
    end
  endtask

  // Queue expectations for the state reached (after a clock if adv), then compare
  task automatic step(input string tag, input bit adv, input int s,
                      input logic [1:0] a, input int sh, input int sc);
    push({tag, ".ctrl"},  16'(ctl(s, a)));
    push({tag, ".alive"}, 16'(a));
    push({tag, ".shots"}, 16'(sh));
    push({tag, ".score"}, 16'(sc));
    if (adv) @(negedge clk);
    pop_check(16'(obs_ctl()));
    pop_check(16'(bus.targets_alive));
    pop_check(16'(bus.shots_left));
    pop_check(16'(bus.score));
  endtask

  initial begin
    reset = 1'b1;
    bus.key = 1'b0;
    bus.sprite_target_within_screen = 2'b11;
    bus.sprite_torpedo_within_screen = 1'b1;
    bus.collision = 2'b00;
    bus.end_of_game_timer_running = 1'b0;

    repeat (2) @(negedge clk);
    step("reset", 0, S_IDLE, 2'b00, 0, 0);
    reset = 1'b0;
    step("rel_idle", 0, S_IDLE, 2'b00, 0, 0);
    step("start", 1, S_START, 2'b00, 0, 0);
    step("wait0", 1, S_WAIT, 2'b11, 3, 0);

    // Round 1: three misses then loss
    for (int k = 3; k >= 1; k--) begin
      bus.key = 1'b1;
      step("miss_launch", 1, S_LAUNCH, 2'b11, k, 0);
      bus.key = 1'b0;
      step("miss_fly", 1, S_FLY, 2'b11, k - 1, 0);
      bus.sprite_torpedo_within_screen = 1'b0;
      if (k > 1) step("miss_back", 1, S_WAIT, 2'b11, k - 1, 0);
      else       step("miss_end", 1, S_SET, 2'b11, 0, 0);
      bus.sprite_torpedo_within_screen = 1'b1;
    end
    bus.end_of_game_timer_running = 1'b1;
    step("lost1", 1, S_LOST, 2'b11, 0, 0);
    step("lost1_hold", 1, S_LOST, 2'b11, 0, 0);
    bus.end_of_game_timer_running = 1'b0;
    step("r2_start", 1, S_START, 2'b11, 0, 0);
    step("r2_wait", 1, S_WAIT, 2'b11, 3, 0);

    // Round 2: double hit in one FLY cycle
    bus.key = 1'b1;
    step("dbl_launch", 1, S_LAUNCH, 2'b11, 3, 0);
    bus.key = 1'b0;
    step("dbl_fly", 1, S_FLY, 2'b11, 2, 0);
    bus.collision = 2'b11;
    step("dbl_hit", 1, S_HIT, 2'b11, 2, 0);
    bus.collision = 2'b00;
    step("dbl_set", 1, S_SET, 2'b00, 2, 2);
    bus.end_of_game_timer_running = 1'b1;
    step("won2", 1, S_WON, 2'b00, 2, 2);
    step("won2_hold", 1, S_WON, 2'b00, 2, 2);
    bus.end_of_game_timer_running = 1'b0;
    step("r3_start", 1, S_START, 2'b00, 2, 2);
    step("r3_wait", 1, S_WAIT, 2'b11, 3, 2);

    // Round 3: single hits on target 0 then target 1, score saturates
    bus.key = 1'b1;
    step("h0_launch", 1, S_LAUNCH, 2'b11, 3, 2);
    bus.key = 1'b0;
    step("h0_fly", 1, S_FLY, 2'b11, 2, 2);
    bus.collision = 2'b01;
    step("h0_hit", 1, S_HIT, 2'b11, 2, 2);
    bus.collision = 2'b00;
    step("h0_wait", 1, S_WAIT, 2'b10, 2, 3);
    bus.key = 1'b1;
    step("h1_launch", 1, S_LAUNCH, 2'b10, 2, 3);
    bus.key = 1'b0;
    step("h1_fly", 1, S_FLY, 2'b10, 1, 3);
    bus.collision = 2'b10;
    step("h1_hit", 1, S_HIT, 2'b10, 1, 3);
    bus.collision = 2'b00;
    step("h1_set", 1, S_SET, 2'b00, 1, 3);
    bus.end_of_game_timer_running = 1'b1;
    step("won3", 1, S_WON, 2'b00, 1, 3);
    step("won3_hold", 1, S_WON, 2'b00, 1, 3);
    bus.end_of_game_timer_running = 1'b0;
    step("r4_start", 1, S_START, 2'b00, 1, 3);
    step("r4_wait", 1, S_WAIT, 2'b11, 3, 3);

    // Round 4: fifth hit held at saturation, off-screen handling, collisions ignored in WAIT_KEY
    bus.key = 1'b1;
    step("sat_launch", 1, S_LAUNCH, 2'b11, 3, 3);
    bus.key = 1'b0;
    step("sat_fly", 1, S_FLY, 2'b11, 2, 3);
    bus.collision = 2'b01;
    step("sat_hit", 1, S_HIT, 2'b11, 2, 3);
    bus.collision = 2'b00;
    step("sat_wait", 1, S_WAIT, 2'b10, 2, 3);
    bus.collision = 2'b11;
    step("wait_coll", 1, S_WAIT, 2'b10, 2, 3);
    bus.collision = 2'b00;
    bus.sprite_target_within_screen = 2'b10;
    step("dead_off", 1, S_WAIT, 2'b10, 2, 3);
    bus.sprite_target_within_screen = 2'b01;
    step("alive_off", 1, S_SET, 2'b10, 2, 3);
    bus.sprite_target_within_screen = 2'b11;
    step("lost4", 1, S_LOST, 2'b10, 2, 3);
    step("r5_start", 1, S_START, 2'b10, 2, 3);
    step("r5_wait", 1, S_WAIT, 2'b11, 3, 3);

    // Round 5: reset asserted mid-FLY clears everything at once
    bus.key = 1'b1;
    step("rst_launch", 1, S_LAUNCH, 2'b11, 3, 3);
    bus.key = 1'b0;
    step("rst_fly", 1, S_FLY, 2'b11, 2, 3);
    reset = 1'b1;
    #1;
    step("rst_async", 0, S_IDLE, 2'b00, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    step("rst_idle", 0, S_IDLE, 2'b00, 0, 0);
    step("rst_start", 1, S_START, 2'b00, 0, 0);
    step("rst_wait", 1, S_WAIT, 2'b11, 3, 0);

    n_tests++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d entries left required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/game_master_fsm_multi.md
Name: game_master_fsm_multi

Overview:
Parametrised next-generation game master for the torpedo game. It sequences one round against N_TARGETS independently moving targets, with a limited magazine of N_SHOTS torpedoes. It tracks which targets are still alive, keeps a saturating hit score across rounds, and drives per-target sprite control vectors plus the shared torpedo sprite and the end-of-game timer.

Parameters:
N_TARGETS, 2, number of target sprites (1..8)
N_SHOTS, 3, torpedoes per round (>=1)
SCORE_W, 8, score counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
key  in  1  fire request, level-sampled each cycle
sprite_target_write_xy  out  N_TARGETS  per-target load start position
sprite_target_write_dxy  out  N_TARGETS  per-target load velocity
sprite_target_enable_update  out  N_TARGETS  per-target motion enable
sprite_target_within_screen  in  N_TARGETS  per-target on-screen flag
sprite_torpedo_write_xy  out  1  load torpedo launch position
sprite_torpedo_write_dxy  out  1  load torpedo velocity (aim)
sprite_torpedo_enable_update  out  1  torpedo motion enable
sprite_torpedo_within_screen  in  1  torpedo on-screen flag
collision  in  N_TARGETS  torpedo-vs-target overlap, one bit per target
end_of_game_timer_start  out  1  one-cycle timer start pulse
end_of_game_timer_running  in  1  timer busy
game_won  out  1  high throughout the WON state
targets_alive  out  N_TARGETS  alive mask; also used as per-target visibility
shots_left  out  clog2(N_SHOTS+1)  remaining torpedoes
score  out  SCORE_W  cumulative hits, saturating

Behaviour:
- Reset state is IDLE. On reset, all outputs are 0: alive=0, shots_left=0, score=0, collision register=0.
- Reset asserted mid-round aborts the round immediately. The first cycle after reset release is IDLE, followed by START_ROUND.
- Control outputs are decoded from the state register only (Moore).
- IDLE -> START_ROUND unconditionally.
- START_ROUND:
  - target_write_xy and target_write_dxy are all ones; torpedo_write_xy=1.
  - At the clock edge: alive <= all ones, shots_left <= N_SHOTS.
  - Next state: WAIT_KEY.
- WAIT_KEY:
  - target_enable_update = alive; torpedo_write_dxy=1.
  - Priority order:
    1. key and shots_left!=0 -> LAUNCH.
    2. round_over -> START_END_TIMER.
    3. Otherwise stay.
  - Collisions are ignored in this state.
- LAUNCH:
  - torpedo_write_xy=1; shots_left decrements at the clock edge.
  - Next state: FLY.
- FLY:
  - torpedo_enable_update=1; torpedo_write_dxy=1; target_enable_update = alive.
  - Priority order:
    1. Any bit of (collision & alive) -> HIT.
    2. An alive target leaves the screen -> START_END_TIMER (loss).
    3. Torpedo leaves the screen -> WAIT_KEY if shots_left!=0, else START_END_TIMER.
    4. Otherwise stay.
- hit_mask is (collision & alive), registered in the FLY cycle. It is consumed in HIT, one cycle later.
- HIT:
  - At the clock edge: alive <= alive & ~hit_mask; score <= min(score + popcount(hit_mask), 2^SCORE_W - 1).
  - Next state: START_END_TIMER if the new alive==0 or shots_left==0, else WAIT_KEY.
  - The torpedo that hit is consumed.
- round_over = (alive==0) | any(alive & ~target_within_screen) | (shots_left==0).
  - Dead targets never cause a loss and never collide.
- START_END_TIMER:
  - end_of_game_timer_start=1 for exactly one cycle.
  - Next state: WON if alive==0, else LOST.
- WON / LOST:
  - game_won=1 only in WON.
  - Stay while timer_running, else go to START_ROUND.
- score persists across rounds and is cleared only by reset. It holds at the saturation value when saturated.
- Simultaneous collisions on several targets in one cycle all count.

Test Plan:
- N_TARGETS=2, N_SHOTS=3; release reset. Required: IDLE, then START_ROUND with target_write_xy=2'b11 for 1 cycle; alive=2'b11, shots_left=3.
- Press key; torpedo exits the screen with no collision. Required: shots_left 3->2, return to WAIT_KEY; repeat until 0. Required: timer_start pulse, then LOST, game_won=0.
- Launch; collision=2'b01 for one cycle. Required: alive=2'b10, score=1, back to WAIT_KEY. Launch; collision=2'b10. Required: alive=0, score=2, timer_start, WON held until timer_running drops, then START_ROUND.
- collision=2'b11 in a single FLY cycle. Required: score +2 in one HIT, WON.
- In WAIT_KEY, alive target 1 goes off-screen. Required: START_END_TIMER next cycle, LOST. Dead target 0 going off-screen has no effect.
- SCORE_W=2: achieve 5 hits over rounds. Required: score saturates at 3. Assert reset mid-FLY. Required: all outputs 0 immediately.
